// File: rtl/control_transfer_predictor_pkg.sv
// rtl/control_transfer_predictor_pkg.sv - shared types and constants for the control transfer predictor
//
// Purpose: branch funct3 encodings, redirect-select encodings, the 2-bit
// branch history counter type and the helpers that decode branch direction
// and step a counter.
package control_transfer_predictor_pkg;

  // Conditional branch funct3 encodings (RV32I)
  localparam logic [2:0] FUNCT3_BRANCH_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BRANCH_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BRANCH_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BRANCH_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BRANCH_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BRANCH_BGEU = 3'b111;

  // Source the front end must take its next PC from
  typedef enum logic [1:0] {
    REDIRECT_NONE     = 2'b00,
    REDIRECT_TARGET   = 2'b01,  // branch / JAL target
    REDIRECT_JALR     = 2'b10,  // {(rs1+imm)[31:1],0}
    REDIRECT_FALLTHRU = 2'b11   // resolve_pc + 4
  } redirect_sel_t;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bht_ctr_t;

  // Actual branch direction. The ALU reports only "difference/compare is zero";
  // the sense of that flag depends on which comparison the branch performs.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic result_equal_zero);
    logic taken;
    case (funct3)
      FUNCT3_BRANCH_BEQ,
      FUNCT3_BRANCH_BGE,
      FUNCT3_BRANCH_BGEU: taken = result_equal_zero;
      FUNCT3_BRANCH_BNE,
      FUNCT3_BRANCH_BLT,
      FUNCT3_BRANCH_BLTU: taken = ~result_equal_zero;
      default:            taken = 1'b0;  // 010/011 are not branch encodings
    endcase
    return taken;
  endfunction

  // Saturating step of a 2-bit counter
  function automatic bht_ctr_t ctr_update(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t next;
    case (ctr)
      STRONG_NT: next = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   next = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    next = taken ? STRONG_T : WEAK_NT;
      default:   next = taken ? STRONG_T : WEAK_T;
    endcase
    return next;
  endfunction

endpackage

// File: rtl/control_transfer_predictor_bht_counter_table.sv
// rtl/control_transfer_predictor_bht_counter_table.sv - array of 2-bit branch history counters
//
// Purpose: BHT_ENTRIES saturating counters, one combinational read port for
// the fetch stage and one read-modify-write update port for the execute stage.
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset (all counters -> WEAK_NT)
//   rd_index         fetch-side index
//   rd_counter       counter at rd_index (pre-update value, no bypass)
//   wr_valid         apply one saturating update this cycle
//   wr_index         index to update
//   wr_taken         direction to train towards
module bht_counter_table
  import control_transfer_predictor_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 16
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [$clog2(BHT_ENTRIES)-1:0] rd_index,
  output bht_ctr_t                       rd_counter,
  input  logic                           wr_valid,
  input  logic [$clog2(BHT_ENTRIES)-1:0] wr_index,
  input  logic                           wr_taken
);

  bht_ctr_t ctr_q [BHT_ENTRIES];

  // Read straight from the registers: a same-cycle update to the same entry
  // is only visible after the edge.
  assign rd_counter = ctr_q[rd_index];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        ctr_q[i] <= WEAK_NT;
      end
    end else if (wr_valid) begin
      ctr_q[wr_index] <= ctr_update(ctr_q[wr_index], wr_taken);
    end
  end

endmodule

// File: rtl/control_transfer_predictor.sv
// rtl/control_transfer_predictor.sv - bimodal branch predictor with execute-stage redirect generation
//
// Purpose: predicts conditional-branch direction at fetch from a table of
// 2-bit counters, trains the table at resolve, and produces a registered
// one-cycle redirect request for mispredicted branches, JAL and JALR.
// Optional feature: define CONTROL_TRANSFER_PERF_EN to add saturating
// branch / mispredict performance counters and their output ports.
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   fetch_valid, fetch_pc     fetch lookup
//   predict_taken             combinational prediction for fetch_pc
//   resolve_*                 execute-stage resolution of one instruction
//   branch/jal/jalr_enable    instruction class (priority branch > jal > jalr)
//   result_equal_zero         ALU comparison flag
//   inst_funct3               branch condition
//   redirect_valid/select     registered redirect request (see redirect_sel_t)
//   mispredict                registered conditional-branch direction miss
//   perf_branch_count         (CONTROL_TRANSFER_PERF_EN) resolved branches
//   perf_mispredict_count     (CONTROL_TRANSFER_PERF_EN) mispredicts
module control_transfer_predictor
  import control_transfer_predictor_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 16,
  parameter int unsigned PC_WIDTH    = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                fetch_valid,
  input  logic [PC_WIDTH-1:0] fetch_pc,
  output logic                predict_taken,
  input  logic                resolve_valid,
  input  logic [PC_WIDTH-1:0] resolve_pc,
  input  logic                resolve_predicted_taken,
  input  logic                branch_enable,
  input  logic                jal_enable,
  input  logic                jalr_enable,
  input  logic                result_equal_zero,
  input  logic [2:0]          inst_funct3,
  output logic                redirect_valid,
  output logic [1:0]          redirect_select,
  output logic                mispredict
`ifdef CONTROL_TRANSFER_PERF_EN
  ,
  output logic [31:0]         perf_branch_count,
  output logic [31:0]         perf_mispredict_count
`endif
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0] fetch_index;
  logic [IDX_W-1:0] resolve_index;
  bht_ctr_t         fetch_ctr;
  logic             branch_update;
  logic             actual_taken;

  redirect_sel_t    select_d;
  logic             mispredict_d;
  redirect_sel_t    select_q;
  logic             mispredict_q;

  // Word-aligned PCs: drop the byte offset, keep just enough bits to index.
  assign fetch_index   = fetch_pc[IDX_W+1:2];
  assign resolve_index = resolve_pc[IDX_W+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[PC_WIDTH-1:IDX_W+2], fetch_pc[1:0],
                            resolve_pc[PC_WIDTH-1:IDX_W+2], resolve_pc[1:0]};

  assign branch_update = resolve_valid & branch_enable;
  assign actual_taken  = branch_taken(inst_funct3, result_equal_zero);

  bht_counter_table #(
    .BHT_ENTRIES(BHT_ENTRIES)
  ) u_bht (
    .clock      (clock),
    .reset_n    (reset_n),
    .rd_index   (fetch_index),
    .rd_counter (fetch_ctr),
    .wr_valid   (branch_update),
    .wr_index   (resolve_index),
    .wr_taken   (actual_taken)
  );

  // Counter MSB is the direction; counters 10/11 predict taken.
  assign predict_taken = fetch_valid & fetch_ctr[1];

  // Redirect decision. A correctly predicted branch needs no redirect, and
  // because branch_enable has top priority it also masks jal/jalr.
  always_comb begin
    select_d     = REDIRECT_NONE;
    mispredict_d = 1'b0;
    if (resolve_valid) begin
      if (branch_enable) begin
        if (actual_taken && !resolve_predicted_taken) begin
          select_d     = REDIRECT_TARGET;
          mispredict_d = 1'b1;
        end else if (!actual_taken && resolve_predicted_taken) begin
          select_d     = REDIRECT_FALLTHRU;
          mispredict_d = 1'b1;
        end
      end else if (jal_enable) begin
        select_d = REDIRECT_TARGET;
      end else if (jalr_enable) begin
        select_d = REDIRECT_JALR;
      end
    end
  end

  // Reloaded every cycle, so a redirect lasts one cycle unless re-requested.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      select_q     <= REDIRECT_NONE;
      mispredict_q <= 1'b0;
    end else begin
      select_q     <= select_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign redirect_valid  = (select_q != REDIRECT_NONE);
  assign redirect_select = select_q;
  assign mispredict      = mispredict_q;

`ifdef CONTROL_TRANSFER_PERF_EN
  logic [31:0] branch_count_q;
  logic [31:0] mispredict_count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (branch_update && branch_count_q != 32'hFFFF_FFFF) begin
        branch_count_q <= branch_count_q + 32'd1;
      end
      if (mispredict_d && mispredict_count_q != 32'hFFFF_FFFF) begin
        mispredict_count_q <= mispredict_count_q + 32'd1;
      end
    end
  end

  assign perf_branch_count     = branch_count_q;
  assign perf_mispredict_count = mispredict_count_q;
`endif

endmodule

// File: tb/tb_control_transfer_predictor.sv
// tb/tb_control_transfer_predictor.sv - directed self-checking bench for control_transfer_predictor
module tb_control_transfer_predictor;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        predict_taken;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_predicted_taken;
  logic        branch_enable;
  logic        jal_enable;
  logic        jalr_enable;
  logic        result_equal_zero;
  logic [2:0]  inst_funct3;
  logic        redirect_valid;
  logic [1:0]  redirect_select;
  logic        mispredict;
`ifdef CONTROL_TRANSFER_PERF_EN
  logic [31:0] perf_branch_count;
  logic [31:0] perf_mispredict_count;
`endif

  int n_asserts = 0;
  int n_fails   = 0;

  always #5 clock = ~clock;

  control_transfer_predictor dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .fetch_valid             (fetch_valid),
    .fetch_pc                (fetch_pc),
    .predict_taken           (predict_taken),
    .resolve_valid           (resolve_valid),
    .resolve_pc              (resolve_pc),
    .resolve_predicted_taken (resolve_predicted_taken),
    .branch_enable           (branch_enable),
    .jal_enable              (jal_enable),
    .jalr_enable             (jalr_enable),
    .result_equal_zero       (result_equal_zero),
    .inst_funct3             (inst_funct3),
    .redirect_valid          (redirect_valid),
    .redirect_select         (redirect_select),
    .mispredict              (mispredict)
`ifdef CONTROL_TRANSFER_PERF_EN
    ,
    .perf_branch_count       (perf_branch_count),
    .perf_mispredict_count   (perf_mispredict_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_redirect(input string tag, input logic v, input logic [1:0] sel, input logic m);
    check({tag, "_valid"}, {31'd0, redirect_valid}, {31'd0, v});
    check({tag, "_select"}, {30'd0, redirect_select}, {30'd0, sel});
    check({tag, "_mispredict"}, {31'd0, mispredict}, {31'd0, m});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic pred, input logic br, input logic jal,
                         input logic jalr, input logic zero, input logic [2:0] f3);
    resolve_valid           = 1'b1;
    resolve_pc              = pc;
    resolve_predicted_taken = pred;
    branch_enable           = br;
    jal_enable              = jal;
    jalr_enable             = jalr;
    result_equal_zero       = zero;
    inst_funct3             = f3;
    step();
  endtask

  task automatic idle();
    resolve_valid = 1'b0;
    branch_enable = 1'b0;
    jal_enable    = 1'b0;
    jalr_enable   = 1'b0;
    step();
  endtask

  task automatic predict(input string tag, input logic [31:0] pc, input logic expected);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    #1;
    check(tag, {31'd0, predict_taken}, {31'd0, expected});
  endtask

  initial begin
    reset_n = 1'b0;
    fetch_valid = 1'b0;
    fetch_pc = 32'h0;
    resolve_valid = 1'b0;
    resolve_pc = 32'h0;
    resolve_predicted_taken = 1'b0;
    branch_enable = 1'b0;
    jal_enable = 1'b0;
    jalr_enable = 1'b0;
    result_equal_zero = 1'b0;
    inst_funct3 = 3'b000;

    // Reset state
    #12;
    check_redirect("reset", 1'b0, 2'b00, 1'b0);
`ifdef CONTROL_TRANSFER_PERF_EN
    check("reset_perf_branch", perf_branch_count, 32'd0);
    check("reset_perf_mispredict", perf_mispredict_count, 32'd0);
`endif
    reset_n = 1'b1;
    predict("after_reset_predict_0x100", 32'h100, 1'b0);

    // BEQ at 0x100 taken three times: 01 -> 10 -> 11 -> 11
    resolve(32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
    check_redirect("beq1", 1'b1, 2'b01, 1'b1);
    predict("beq1_predict", 32'h100, 1'b1);
    fetch_valid = 1'b0;
    #1;
    check("fetch_invalid_predict", {31'd0, predict_taken}, 32'd0);
    resolve(32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
    check_redirect("beq2", 1'b1, 2'b01, 1'b1);
    resolve(32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
    check_redirect("beq3_correct", 1'b0, 2'b00, 1'b0);
    predict("beq3_predict", 32'h100, 1'b1);
`ifdef CONTROL_TRANSFER_PERF_EN
    check("perf_branch_after_beq", perf_branch_count, 32'd3);
    check("perf_mispredict_after_beq", perf_mispredict_count, 32'd2);
`endif
    idle();
    check_redirect("idle_after_beq", 1'b0, 2'b00, 1'b0);

    // Saturated at 11: one not-taken leaves 10, still predicting taken
    resolve(32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001);
    check_redirect("bne_0x100_nt", 1'b1, 2'b11, 1'b1);
    predict("sat_high_predict", 32'h100, 1'b1);

    // BNE at 0x104 predicted taken, actually not taken
    resolve(32'h104, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001);
    check_redirect("bne_0x104", 1'b1, 2'b11, 1'b1);
    idle();
    check_redirect("bne_hold_one_cycle", 1'b0, 2'b00, 1'b0);
    // Counter at 00: another not-taken stays 00, then taken gives 01
    resolve(32'h104, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001);
    check_redirect("bne_0x104_correct", 1'b0, 2'b00, 1'b0);
    resolve(32'h104, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
    check_redirect("beq_0x104_taken", 1'b1, 2'b01, 1'b1);
    predict("sat_low_predict", 32'h104, 1'b0);

    // Direction decode corners
    resolve(32'h10C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010);
    check_redirect("funct3_010_never_taken", 1'b1, 2'b11, 1'b1);
    resolve(32'h10C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100);
    check_redirect("blt_taken", 1'b1, 2'b01, 1'b1);
    resolve(32'h10C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b111);
    check_redirect("bgeu_taken_correct", 1'b0, 2'b00, 1'b0);

    // JAL then JALR back to back
    resolve(32'h108, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000);
    check_redirect("jal", 1'b1, 2'b01, 1'b0);
    resolve(32'h108, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
    check_redirect("jalr", 1'b1, 2'b10, 1'b0);
    idle();
    check_redirect("jalr_hold_one_cycle", 1'b0, 2'b00, 1'b0);
    predict("jal_no_training", 32'h108, 1'b0);

    // Priority
    resolve(32'h110, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000);
    check_redirect("branch_over_jal", 1'b0, 2'b00, 1'b0);
    resolve(32'h110, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000);
    check_redirect("jal_over_jalr", 1'b1, 2'b01, 1'b0);
    resolve(32'h110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    check_redirect("no_enable", 1'b0, 2'b00, 1'b0);
    idle();

    // Same-cycle fetch and resolve on index 5: no bypass
    resolve_valid = 1'b1;
    resolve_pc = 32'h54;
    resolve_predicted_taken = 1'b0;
    branch_enable = 1'b1;
    result_equal_zero = 1'b1;
    inst_funct3 = 3'b000;
    predict("same_cycle_old_value", 32'h14, 1'b0);
    step();
    idle();
    predict("same_cycle_after_edge", 32'h14, 1'b1);
    predict("byte_offset_ignored", 32'h17, 1'b1);

    // Asynchronous reset during a pending redirect
    resolve(32'h108, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    check_redirect("pre_reset_jal", 1'b1, 2'b01, 1'b0);
    resolve_valid = 1'b0;
    jal_enable = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_redirect("async_reset", 1'b0, 2'b00, 1'b0);
    check("async_reset_counters", {31'd0, predict_taken}, 32'd0);
`ifdef CONTROL_TRANSFER_PERF_EN
    check("async_reset_perf_branch", perf_branch_count, 32'd0);
`endif
    #2;
    reset_n = 1'b1;
    resolve(32'h108, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    check_redirect("first_edge_after_reset", 1'b1, 2'b01, 1'b0);
    idle();
    check_redirect("final_idle", 1'b0, 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
